// File: rtl/packet_fifo_reader_pkg.sv
// packet_fifo_reader_pkg
//   Shared definitions for the packet FIFO read-side sequencer:
//   - state_e         : sequencer state encoding
//   - min_skid_depth  : smallest skid depth that still sustains 1 beat/cycle
package packet_fifo_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2,
        ST_POP    = 2'd3
    } state_e;

    // Credits must cover every read still in the memory pipeline, the beat
    // being popped this cycle and the one being issued.
    function automatic int min_skid_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/packet_skid_fifo.sv
// packet_skid_fifo
//   Single-clock first-word-fall-through register FIFO that absorbs the
//   memory read latency between the sequencer and the output stream.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     wr_en_i      write strobe (never throttled; the caller meters credits)
//     wr_data_i    write word
//     rd_en_i      pop the head (ignored when empty)
//     valid_o      head is valid
//     rd_data_o    head word
//     count_o      number of stored entries
module packet_skid_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_rd = rd_en_i && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            // Simultaneous write and pop leave the count unchanged.
            case ({wr_en_i, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o   = (count_q != '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // A write into a full skid without a matching pop means the credit
    // accounting upstream is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en_i && !do_rd && (count_q == CW'(DEPTH))))
        else $error("packet_skid_fifo overflow");

endmodule

// File: rtl/packet_fifo_reader.sv
// packet_fifo_reader
//   Read-side sequencer for the cross-clock packet FIFO (read clock domain).
//   Accepts a packet length, waits for the packet to be committed, reads it
//   by offset, streams it out with last-beat marking and pops it.
//   Ports:
//     clk, rst_n                          clock, asynchronous active-low reset
//     len_valid, len_data, len_ready      sideband length queue
//     fifo_rd_size                        committed words available
//     fifo_rd_en, fifo_rd_offset          random-access read request
//     fifo_rd_data                        read data, READ_LATENCY after request
//     fifo_rd_pop_packet, fifo_rd_packet_size   packet release
//     out_valid, out_ready, out_data, out_last  output beat stream
//     err_overlength                      pulse on a length above 2^ADDR_BITS
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | take the next length; drop zero and overlength entries
//   ST_WAIT   | wait until the whole packet is committed in the FIFO
//   ST_STREAM | issue one read per cycle while skid credits allow
//   ST_POP    | release the packet in the FIFO (single-cycle pulse)
module packet_fifo_reader
    import packet_fifo_reader_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 2,
    parameter int SKID_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 len_valid,
    input  logic [ADDR_BITS:0]   len_data,
    output logic                 len_ready,
    input  logic [ADDR_BITS:0]   fifo_rd_size,
    output logic                 fifo_rd_en,
    output logic [ADDR_BITS-1:0] fifo_rd_offset,
    input  logic [WIDTH-1:0]     fifo_rd_data,
    output logic                 fifo_rd_pop_packet,
    output logic [ADDR_BITS:0]   fifo_rd_packet_size,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic                 err_overlength
);

    localparam int LW = ADDR_BITS + 1;
    localparam int CW = $clog2(SKID_DEPTH + 1);

    if (SKID_DEPTH < min_skid_depth(READ_LATENCY)) begin : g_bad_depth
        $error("SKID_DEPTH too small for READ_LATENCY");
    end

    state_e                  state_q, state_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           cnt_q, cnt_d;
    logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [READ_LATENCY-1:0] last_pipe_q, last_pipe_d;
    logic [CW-1:0]           in_flight_q, in_flight_d;
    logic                    err_q, err_d;

    logic                    rd_en;
    logic                    rd_last;
    logic                    pop_pkt;
    logic                    issue_ok;
    logic                    rd_arrive;
    logic                    skid_valid;
    logic                    skid_pop;
    logic [WIDTH:0]          skid_head;
    logic [CW-1:0]           skid_count;
    logic [CW:0]             credit_sum;

    // Every read either sits in the memory pipeline or in the skid, so the
    // skid can never be written beyond its depth.
    assign credit_sum = {1'b0, in_flight_q} + {1'b0, skid_count} + (CW+1)'(1);
    assign issue_ok   = (credit_sum <= (CW+1)'(SKID_DEPTH));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        len_ready = 1'b0;
        rd_en     = 1'b0;
        rd_last   = 1'b0;
        pop_pkt   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                len_ready = len_valid;
                if (len_valid) begin
                    len_d = len_data;
                    if (len_data[ADDR_BITS] && (len_data[ADDR_BITS-1:0] != '0)) begin
                        err_d = 1'b1;
                    end else if (len_data != '0) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = '0;
                if (fifo_rd_size >= len_q) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (issue_ok) begin
                    rd_en   = 1'b1;
                    rd_last = (cnt_q == len_q - 1'b1);
                    cnt_d   = cnt_q + 1'b1;
                    if (rd_last) begin
                        state_d = ST_POP;
                    end
                end
            end
            ST_POP: begin
                pop_pkt = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Valid and last tag follow each read through the memory latency.
    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = rd_en;
        last_pipe_d[0] = rd_last;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    assign rd_arrive   = vld_pipe_q[READ_LATENCY-1];
    assign in_flight_d = in_flight_q + CW'(rd_en) - CW'(rd_arrive);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            in_flight_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            in_flight_q <= in_flight_d;
            err_q       <= err_d;
        end
    end

    assign skid_pop = skid_valid && out_ready;

    packet_skid_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (rd_arrive),
        .wr_data_i ({last_pipe_q[READ_LATENCY-1], fifo_rd_data}),
        .rd_en_i   (skid_pop),
        .valid_o   (skid_valid),
        .rd_data_o (skid_head),
        .count_o   (skid_count)
    );

    assign out_valid           = skid_valid;
    assign out_data            = skid_head[WIDTH-1:0];
    assign out_last            = skid_valid && skid_head[WIDTH];
    assign fifo_rd_en          = rd_en;
    assign fifo_rd_offset      = rd_en ? cnt_q[ADDR_BITS-1:0] : '0;
    assign fifo_rd_pop_packet  = pop_pkt;
    assign fifo_rd_packet_size = pop_pkt ? len_q : '0;
    assign err_overlength      = err_q;

endmodule
